// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one memory port between the CPU DM stage and a debug port.
// Optional starvation guard for debug is compiled in with `define DM_ARB_STARVE_EN.
module dm_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    input  logic              cpu_halted,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       stall_cnt
);
    typedef enum logic {ARB, LOCK} state_e;

    state_e      state_q, state_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        sel_dbg, sel_cpu, starve_hit;

`ifdef DM_ARB_STARVE_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);
    logic [2:0] starve_q, starve_d;

    assign starve_hit = (starve_q == STARVE_MAX);

    always_comb begin
        starve_d = starve_q;
        if (en) begin
            if (sel_dbg || !dbg_req)
                starve_d = 3'd0;
            else if (starve_q != STARVE_MAX)
                starve_d = starve_q + 3'd1;
        end
    end
`else
    // Forced debug slots are compiled out; this is constant false for any legal limit.
    assign starve_hit = (STARVE_LIM < 0);
`endif

    always_comb begin
        sel_dbg = 1'b0;
        sel_cpu = 1'b0;
        if (en && !rst) begin
            if (state_q == LOCK) begin
                sel_dbg = dbg_req;
            end else begin
                sel_dbg = dbg_req && (cpu_halted || !cpu_req || starve_hit);
                sel_cpu = cpu_req && !sel_dbg;
            end
        end
    end

    assign dbg_gnt   = sel_dbg;
    assign cpu_stall = cpu_req && !sel_cpu;
    assign mem_en    = sel_dbg || sel_cpu;
    assign mem_we    = sel_dbg ? dbg_we : (sel_cpu && cpu_we);
    assign mem_addr  = sel_dbg ? dbg_addr : cpu_addr;
    assign mem_wdata = sel_dbg ? dbg_wdata : cpu_wdata;
    assign stall_cnt = stall_cnt_q;

    // Memory data arrives during the rvalid cycle; pass it through then and keep
    // the captured copy on dbg_rdata afterwards so the port never goes stale.
    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rvalid_q ? mem_rdata : rdata_q;

    always_comb begin
        state_d     = state_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        stall_cnt_d = stall_cnt_q;
        if (en) begin
            case (state_q)
                ARB:     if (sel_dbg && dbg_lock) state_d = LOCK;
                LOCK:    if (!sel_dbg && !dbg_lock) state_d = ARB;
                default: state_d = ARB;
            endcase
            rvalid_d = sel_dbg && !dbg_we;
            if (rvalid_q)
                rdata_d = mem_rdata;
            if (cpu_stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            stall_cnt_q <= 16'd0;
`ifdef DM_ARB_STARVE_EN
            starve_q    <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef DM_ARB_STARVE_EN
            starve_q    <= starve_d;
`endif
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: rule-level reference model checked every cycle
// plus directed scenarios with literal expectations (works with or without DM_ARB_STARVE_EN).
module tb_dm_arbiter;
    localparam int ADDR_W     = 10;
    localparam int STARVE_LIM = 4;
    localparam int WORDS      = 1 << ADDR_W;

    logic              clk;
    logic              rst = 1'b1, en = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_halted = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [31:0]       cpu_wdata = '0, dbg_wdata = '0;
    logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic              cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [31:0]       dbg_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       stall_cnt;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_halted(cpu_halted),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    // Environment memory: one-cycle read latency, output held between reads.
    logic [31:0] mem [0:WORDS-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Reference model state
    bit          m_lock;
    int          m_starve;
    int          m_stall;
    bit          m_rv;
    logic [31:0] m_rdata;
    logic [31:0] m_mem [0:WORDS-1];

    // Who owns the memory this cycle: 0 none, 1 cpu, 2 debug
    function automatic int winner();
        bit starved;
        if (rst || !en) return 0;
        if (m_lock) return dbg_req ? 2 : 0;
`ifdef DM_ARB_STARVE_EN
        starved = (m_starve >= STARVE_LIM);
`else
        starved = 1'b0;
`endif
        if (dbg_req && (cpu_halted || !cpu_req || starved)) return 2;
        if (cpu_req) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lock   <= 1'b0;
            m_starve <= 0;
            m_stall  <= 0;
            m_rv     <= 1'b0;
            m_rdata  <= 32'd0;
            for (int i = 0; i < WORDS; i++) m_mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (en) begin
            if (winner() == 1 && cpu_we) m_mem[cpu_addr] <= cpu_wdata;
            if (winner() == 2 && dbg_we) m_mem[dbg_addr] <= dbg_wdata;
            m_rv <= (winner() == 2) && !dbg_we;
            if (winner() == 2 && !dbg_we) m_rdata <= m_mem[dbg_addr];
            if (cpu_req && winner() != 1 && m_stall < 65535) m_stall <= m_stall + 1;
            if (winner() == 2)     m_lock <= m_lock || dbg_lock;
            else if (!dbg_lock)    m_lock <= 1'b0;
            if (winner() == 2 || !dbg_req) m_starve <= 0;
            else if (m_starve < STARVE_LIM) m_starve <= m_starve + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_en", mem_en, winner() != 0);
            if (winner() != 0) begin
                check("mem_we",    mem_we,    winner() == 2 ? dbg_we    : cpu_we);
                check("mem_addr",  mem_addr,  winner() == 2 ? dbg_addr  : cpu_addr);
                check("mem_wdata", mem_wdata, winner() == 2 ? dbg_wdata : cpu_wdata);
            end
            check("dbg_gnt",    dbg_gnt,    winner() == 2);
            check("cpu_stall",  cpu_stall,  cpu_req && winner() != 1);
            check("dbg_rvalid", dbg_rvalid, m_rv);
            check("dbg_rdata",  dbg_rdata,  m_rdata);
            check("stall_cnt",  stall_cnt,  m_stall);
            if (dbg_gnt === 1'b1)
                $display("[%0t] dbg %s addr=%0h wdata=%0h", $time, dbg_we ? "wr" : "rd", dbg_addr, dbg_wdata);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Returns the 1-based cycle of the first grant (0 if none within max_cyc).
    task automatic wait_gnt(input int max_cyc, output int cyc, output logic stall_at);
        cyc = 0;
        stall_at = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (dbg_gnt === 1'b1) begin
                cyc = c;
                stall_at = cpu_stall;
            end
            next();
            if (cyc != 0) break;
        end
    endtask

    int   g, n;
    logic s;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        check("idle_mem_en", mem_en, 0);
        check("idle_cpu_stall", cpu_stall, 0);
        check("idle_rvalid", dbg_rvalid, 0);
        check("idle_stall_cnt", stall_cnt, 0);
        next();

        // Continuous CPU traffic against a pending debug read of 0x12
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h05;
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'h12;
`ifdef DM_ARB_STARVE_EN
        wait_gnt(8, g, s);
        check("forced_gnt_cycle", g, 5);
        check("stall_at_forced_gnt", s, 1);
        dbg_req = 0;
        @(negedge clk);
        check("rvalid_after_forced", dbg_rvalid, 1);
        check("rdata_0x12", dbg_rdata, 32'hC0DE_0012);
        check("stall_cnt_after_forced", stall_cnt, 1);
        next();
`else
        wait_gnt(6, g, s);
        check("no_gnt_while_cpu_req", g, 0);
        cpu_req = 0;
        wait_gnt(1, g, s);
        check("gnt_when_cpu_drops", g, 1);
        dbg_req = 0;
        @(negedge clk);
        check("rvalid_after_read", dbg_rvalid, 1);
        check("rdata_0x12", dbg_rdata, 32'hC0DE_0012);
        check("stall_cnt_no_stalls", stall_cnt, 0);
        next();
`endif

        // Halted pipeline, locked burst of four debug writes
        cpu_req = 1; cpu_halted = 1; dbg_lock = 1; dbg_we = 1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1;
            dbg_addr = ADDR_W'(i);
            dbg_wdata = 32'hD00D_0000 + 32'(i);
            wait_gnt(3, g, s);
            if (g != 0) n++;
            check("stall_at_locked_gnt", s, 1);
        end
        check("locked_gnt_count", n, 4);
        dbg_req = 0; cpu_halted = 0;
        @(negedge clk);
        check("lock_blocks_cpu", cpu_stall, 1);
        next();
        dbg_lock = 0;
        @(negedge clk);
        check("unlock_cycle_still_locked", cpu_stall, 1);
        next();
        @(negedge clk);
        check("arb_after_unlock", cpu_stall, 0);
        next();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 10'h02;
        wait_gnt(2, g, s);
        check("readback_gnt", g, 1);
        dbg_req = 0;
        @(negedge clk);
        check("readback_word2", dbg_rdata, 32'hD00D_0002);
        next();

        // Freeze with en=0 while debug is waiting
        cpu_req = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 10'h07;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("pre_freeze_no_gnt", dbg_gnt, 0);
            next();
        end
        en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("freeze_no_gnt", dbg_gnt, 0);
            check("freeze_mem_en", mem_en, 0);
            check("freeze_cpu_stall", cpu_stall, 1);
            next();
        end
        en = 1;
`ifdef DM_ARB_STARVE_EN
        wait_gnt(5, g, s);
        check("gnt_after_thaw", g, 3);
`else
        wait_gnt(4, g, s);
        check("no_gnt_after_thaw", g, 0);
        cpu_req = 0;
        wait_gnt(1, g, s);
        check("gnt_cpu_idle", g, 1);
`endif
        dbg_req = 0;
        @(negedge clk);
        check("rdata_0x07", dbg_rdata, 32'hC0DE_0007);
        next();

        // Reset the cycle after a debug read grant
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 10'h03;
        wait_gnt(2, g, s);
        check("pre_rst_gnt", g, 1);
        dbg_addr = 10'h04;
        rst = 1;
        @(negedge clk);
        check("rst_drops_rvalid", dbg_rvalid, 0);
        check("no_gnt_in_rst", dbg_gnt, 0);
        check("rst_clears_stall_cnt", stall_cnt, 0);
        next();
        rst = 0;
        cpu_req = 1;
        @(negedge clk);
        check("arb_after_rst_gnt", dbg_gnt, 0);
        check("arb_after_rst_cpu", cpu_stall, 0);
        next();
        cpu_req = 0;
        wait_gnt(1, g, s);
        check("post_rst_gnt", g, 1);
        dbg_req = 0;
        @(negedge clk);
        check("post_rst_rvalid", dbg_rvalid, 1);
        check("post_rst_rdata", dbg_rdata, 32'hC0DE_0004);
        next();

        // Hold the CPU out under LOCK long enough to saturate stall_cnt
        dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 10'h09; dbg_wdata = 32'h1234_5678;
        wait_gnt(2, g, s);
        check("sat_lock_gnt", g, 1);
        dbg_req = 0; cpu_req = 1;
        repeat (65540) next();
        @(negedge clk);
        check("stall_cnt_saturates", stall_cnt, 16'hFFFF);
        next();
        dbg_lock = 0; cpu_req = 0;
        next();
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory word-address width.
REQ-002 SHALL have parameter STARVE_LIM, default 4, consecutive debug-denied cycles before a forced debug slot.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  in  1  global enable; 0 freezes all state.
REQ-006 SHALL have ports cpu_req/cpu_we  in  1/1  DM-stage access request / write.
REQ-007 SHALL have ports cpu_addr/cpu_wdata  in  ADDR_W/32  DM-stage address / store data.
REQ-008 SHALL have port cpu_stall  out  1  DM-stage access not served this cycle.
REQ-009 SHALL have port cpu_halted  in  1  pipeline halted; debug gets absolute priority.
REQ-010 SHALL have ports dbg_req/dbg_we/dbg_lock  in  1/1/1  debug request / write / burst-lock.
REQ-011 SHALL have ports dbg_addr/dbg_wdata  in  ADDR_W/32  debug address / write data.
REQ-012 SHALL have ports dbg_gnt/dbg_rvalid  out  1/1  debug access issued / debug read data valid.
REQ-013 SHALL have port dbg_rdata  out  32  debug read data, registered.
REQ-014 SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  out  1/1/ADDR_W/32  memory command, driven combinationally from the selected requester.
REQ-015 SHALL have port mem_rdata  in  32  memory read data, valid one cycle after a read command.
REQ-016 SHALL have port stall_cnt  out  16  saturating count of cpu_stall cycles.

Function
REQ-017 SHALL implement FSM states ARB and LOCK; per cycle, exactly one requester or none is selected.
REQ-018 In ARB with en=1, SHALL select debug if dbg_req and (cpu_halted or !cpu_req or starve==STARVE_LIM), otherwise CPU if cpu_req.
REQ-019 SHALL assert dbg_gnt for one cycle per issued debug access; requester holds dbg_* stable until gnt.
REQ-020 SHALL transition ARB->LOCK when a debug access is granted with dbg_lock=1; in LOCK, every dbg_req is granted and CPU is never selected.
REQ-021 SHALL transition LOCK->ARB in the cycle after a cycle with dbg_lock=0 and no granted debug access.
REQ-022 SHALL drive mem_en=1 only when a requester is selected, with mem_we/mem_addr/mem_wdata taken from that requester.
REQ-023 SHALL assert cpu_stall = cpu_req and CPU not selected, combinationally.
REQ-024 SHALL register dbg_rvalid=1 in the cycle after a granted debug read, and dbg_rdata=mem_rdata in that cycle; debug writes produce no rvalid.
REQ-025 SHALL increment 3-bit starve on cycles with dbg_req and no debug grant, saturating at STARVE_LIM; SHALL clear it on a debug grant or when dbg_req=0.
REQ-026 SHALL increment stall_cnt on each cpu_stall cycle with en=1, holding at 16'hFFFF.
REQ-027 With en=0, SHALL force mem_en=0 and dbg_gnt=0, set cpu_stall=cpu_req, and hold FSM, starve, stall_cnt, dbg_rvalid and dbg_rdata.
REQ-028 Simultaneous cpu_req and dbg_req with starve<STARVE_LIM, cpu_halted=0, state ARB: CPU SHALL win.

Reset
REQ-029 On rst=1, SHALL asynchronously set state=ARB, starve=0, stall_cnt=0, dbg_rvalid=0, dbg_rdata=0.
REQ-030 Reset mid-LOCK or mid-read SHALL drop the pending rvalid; no grant SHALL be issued while rst=1.

Configuration
REQ-031 With macro DM_ARB_STARVE_EN defined, SHALL include the starve counter and forced-slot rule of REQ-018/REQ-025.
REQ-032 Without DM_ARB_STARVE_EN, SHALL omit starve; debug SHALL win in ARB only when cpu_halted or !cpu_req.

Verification
REQ-033 Reset, idle -> mem_en=0, cpu_stall=0, dbg_rvalid=0, stall_cnt=0.
REQ-034 cpu_req=1 continuously with dbg_req=1 read addr 0x12, macro on, STARVE_LIM=4 -> 4 CPU cycles, then dbg_gnt on cycle 5, cpu_stall=1 on cycle 5, dbg_rvalid cycle 6 with memory word 0x12, stall_cnt=1.
REQ-035 Same stimulus, macro off -> dbg_gnt never asserted while cpu_req=1; granted the first cycle cpu_req drops.
REQ-036 cpu_halted=1, dbg_lock=1, four debug writes to 0x00-0x03 -> four gnts, state LOCK, cpu_stall=cpu_req throughout; dbg_lock=0 with dbg_req=0 -> ARB the following cycle.
REQ-037 en=0 for 3 cycles during a pending dbg_req with starve=2 -> no gnt, mem_en=0, starve stays 2, stall_cnt unchanged.
REQ-038 rst pulsed the cycle after a debug read grant -> dbg_rvalid stays 0, state ARB.
